// File: rtl/rx_link_scheduler.sv
// rx_link_scheduler: round-robin arbiter and serial frame transmitter that
// drives the rx instruction link. Frame: start bit (0), data[3:0] MSB first,
// instr[3:0] MSB first, then GAP_BITS idle bit-times of 1.
// Optional feature macro: RX_INSTR_CHECK_EN (rejects instructions outside
// {1,2,4} with an err/done pulse instead of sending a frame).
module rx_link_scheduler #(
  parameter int NREQ       = 4,
  parameter int BIT_CYCLES = 1,
  parameter int GAP_BITS   = 3
) (
  input  logic              clk2,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] instr_bus,
  input  logic [4*NREQ-1:0] data_bus,
  output logic [NREQ-1:0]   grant,
  output logic              done,
  output logic              busy,
  output logic              tx,
  output logic              err
);

  localparam int PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int FLUSH_LEN = (9 + GAP_BITS) * BIT_CYCLES;
  localparam int GAP_LEN   = GAP_BITS * BIT_CYCLES;
  localparam int CW        = $clog2(FLUSH_LEN + 1);

  localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(FLUSH_LEN - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_LEN - 1);
  localparam logic [CW-1:0] GAP_DONE   = CW'(GAP_LEN - 2);

  typedef enum logic [2:0] {
    S_FLUSH, S_IDLE, S_START, S_DATA, S_INSTR, S_GAP, S_BAD
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cyc;
  logic [1:0]      r_bit;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_gidx;
  logic [NREQ-1:0] r_grant;
  logic            r_done;
  logic            r_busy;
  logic            r_tx;
  logic [7:0]      r_sh;

  logic            w_any;
  logic [PW-1:0]   w_sel;
  logic [NREQ-1:0] w_onehot;
  logic [3:0]      w_instr;
  logic [3:0]      w_data;
  logic [PW-1:0]   w_ptr_nxt;
  logic            w_bit_end;
  logic            w_shift;

  // Round-robin pick: first set req at or after r_ptr, wrapping.
  always_comb begin
    w_any = |req;
    w_sel = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(r_ptr) + k) % NREQ]) w_sel = PW'((int'(r_ptr) + k) % NREQ);
    end
    w_onehot = '0;
    for (int j = 0; j < NREQ; j++) w_onehot[j] = (PW'(j) == w_sel);
    w_instr   = instr_bus[4*int'(w_sel) +: 4];
    w_data    = data_bus[4*int'(w_sel) +: 4];
    w_ptr_nxt = (r_gidx == PW'(NREQ - 1)) ? '0 : r_gidx + 1'b1;
    w_bit_end = (r_cyc == BIT_LAST);
    w_shift   = w_bit_end && ((r_state == S_START) || (r_state == S_DATA) ||
                              ((r_state == S_INSTR) && (r_bit != 2'd3)));
  end

`ifdef RX_INSTR_CHECK_EN
  logic r_err;
  logic w_bad;

  // Only clean(1), store(2) and show(4) are legal on the link.
  always_comb begin
    w_bad = !((w_instr == 4'd1) || (w_instr == 4'd2) || (w_instr == 4'd4));
  end
`endif

  // Frame shift register: loaded with {data,instr} at grant, MSB goes out next.
  always_ff @(posedge clk2) begin
    if ((r_state == S_IDLE) && w_any) r_sh <= {w_data, w_instr};
    else if (w_shift)                 r_sh <= {r_sh[6:0], 1'b0};
  end

  // Sequencer: flush, arbitrate, send start/data/instr bits, hold the idle gap.
  always_ff @(posedge clk2) begin
    if (rst) begin
      r_state <= S_FLUSH;
      r_cyc   <= '0;
      r_bit   <= '0;
      r_ptr   <= '0;
      r_gidx  <= '0;
      r_grant <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b1;
      r_tx    <= 1'b1;
`ifdef RX_INSTR_CHECK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_FLUSH: begin
          if (r_cyc == FLUSH_LAST) begin
            r_cyc   <= '0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cyc <= r_cyc + 1'b1;
          end
        end
        S_IDLE: begin
          r_cyc <= '0;
          r_bit <= '0;
          if (w_any) begin
            r_grant <= w_onehot;
            r_gidx  <= w_sel;
            r_busy  <= 1'b1;
`ifdef RX_INSTR_CHECK_EN
            if (w_bad) begin
              r_state <= S_BAD;
            end else begin
              r_tx    <= 1'b0;
              r_state <= S_START;
            end
`else
            r_tx    <= 1'b0;
            r_state <= S_START;
`endif
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_cyc   <= '0;
            r_tx    <= r_sh[7];
            r_state <= S_DATA;
          end else begin
            r_cyc <= r_cyc + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_cyc <= '0;
            r_tx  <= r_sh[7];
            r_bit <= r_bit + 2'd1;
            if (r_bit == 2'd3) r_state <= S_INSTR;
          end else begin
            r_cyc <= r_cyc + 1'b1;
          end
        end
        S_INSTR: begin
          if (w_bit_end) begin
            r_cyc <= '0;
            r_bit <= r_bit + 2'd1;
            if (r_bit == 2'd3) begin
              r_tx    <= 1'b1;
              r_state <= S_GAP;
            end else begin
              r_tx <= r_sh[7];
            end
          end else begin
            r_cyc <= r_cyc + 1'b1;
          end
        end
        S_GAP: begin
          if (r_cyc == GAP_LAST) begin
            r_cyc   <= '0;
            r_done  <= 1'b0;
            r_grant <= '0;
            r_ptr   <= w_ptr_nxt;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            if (r_cyc == GAP_DONE) r_done <= 1'b1;
            r_cyc <= r_cyc + 1'b1;
          end
        end
`ifdef RX_INSTR_CHECK_EN
        S_BAD: begin
          if (r_cyc == '0) begin
            r_err  <= 1'b1;
            r_done <= 1'b1;
            r_cyc  <= r_cyc + 1'b1;
          end else begin
            r_err   <= 1'b0;
            r_done  <= 1'b0;
            r_grant <= '0;
            r_ptr   <= w_ptr_nxt;
            r_busy  <= 1'b0;
            r_cyc   <= '0;
            r_state <= S_IDLE;
          end
        end
`endif
        default: begin
          r_cyc   <= '0;
          r_state <= S_FLUSH;
        end
      endcase
    end
  end

  assign grant = r_grant;
  assign done  = r_done;
  assign busy  = r_busy;
  assign tx    = r_tx;
`ifdef RX_INSTR_CHECK_EN
  assign err   = r_err;
`else
  assign err   = 1'b0;
`endif

endmodule
